// File: rtl/alu_sched_if.sv
// Bundle of the two requester ports, the shared result and the ALU drive
// lines for the round-robin ALU scheduler. The scheduler uses the slave
// modport. Requesters and the ALU sit on the master side.
interface alu_sched_if #(
    parameter int DW = 16
);
    // Port 0: execute stage (operate instructions)
    logic          r0_req_i_w;
    logic [2:0]    r0_op_i_w;
    logic [DW-1:0] r0_s1_i_w;
    logic [DW-1:0] r0_s2_i_w;
    logic          r0_ack_o_r;
    logic          r0_vld_o_r;
    logic          r0_rdy_i_w;
    // Port 1: address/increment path
    logic          r1_req_i_w;
    logic [2:0]    r1_op_i_w;
    logic [DW-1:0] r1_s1_i_w;
    logic [DW-1:0] r1_s2_i_w;
    logic          r1_ack_o_r;
    logic          r1_vld_o_r;
    logic          r1_rdy_i_w;
    // Shared result
    logic [DW-1:0] res_o_r;
    logic [2:0]    nzp_o_r;
    // ALU drive and return
    logic          alu_en_o_r;
    logic [2:0]    alu_op_o_r;
    logic [DW-1:0] alu_s1_o_r;
    logic [DW-1:0] alu_s2_o_r;
    logic [DW-1:0] alu_out_i_w;
    logic          busy_o_w;

    modport slave (
        input  r0_req_i_w, r0_op_i_w, r0_s1_i_w, r0_s2_i_w, r0_rdy_i_w,
        input  r1_req_i_w, r1_op_i_w, r1_s1_i_w, r1_s2_i_w, r1_rdy_i_w,
        input  alu_out_i_w,
        output r0_ack_o_r, r0_vld_o_r, r1_ack_o_r, r1_vld_o_r,
        output res_o_r, nzp_o_r,
        output alu_en_o_r, alu_op_o_r, alu_s1_o_r, alu_s2_o_r,
        output busy_o_w
    );

    modport master (
        output r0_req_i_w, r0_op_i_w, r0_s1_i_w, r0_s2_i_w, r0_rdy_i_w,
        output r1_req_i_w, r1_op_i_w, r1_s1_i_w, r1_s2_i_w, r1_rdy_i_w,
        output alu_out_i_w,
        input  r0_ack_o_r, r0_vld_o_r, r1_ack_o_r, r1_vld_o_r,
        input  res_o_r, nzp_o_r,
        input  alu_en_o_r, alu_op_o_r, alu_s1_o_r, alu_s2_o_r,
        input  busy_o_w
    );
endinterface

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one combinational ALU between two requesters.
// One operation in flight: grant (IDLE) -> drive ALU (EXEC) -> hold result
// until the owner accepts it (RESP). Result carries LC-3 NZP codes.
module alu_sched #(
    parameter int DW = 16
) (
    input logic        clk_i_w,
    input logic        rst_i_w,
    alu_sched_if.slave bus
);
    localparam logic [2:0] ALU_OP_ADD = 3'd0;
    localparam logic [2:0] ALU_OP_AND = 3'd1;
    localparam logic [2:0] ALU_OP_NOT = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_owner;   // port that owns the in-flight operation
    logic          r_last;    // last granted port; reset = port 1

    logic          w_any_req;
    logic          w_win;
    logic [2:0]    w_win_op;
    logic [DW-1:0] w_win_s1;
    logic [DW-1:0] w_win_s2;
    logic          w_win_op_ok;
    logic [DW-1:0] w_res;
    logic [2:0]    w_nzp;
    logic          w_accept;

    // Arbitration, winner operand mux, result gating and NZP derivation
    always_comb begin
        w_any_req   = bus.r0_req_i_w | bus.r1_req_i_w;
        // Both requesting: the port not granted last wins; otherwise the lone requester
        w_win       = (bus.r0_req_i_w & bus.r1_req_i_w) ? ~r_last : bus.r1_req_i_w;
        w_win_op    = w_win ? bus.r1_op_i_w : bus.r0_op_i_w;
        w_win_s1    = w_win ? bus.r1_s1_i_w : bus.r0_s1_i_w;
        w_win_s2    = w_win ? bus.r1_s2_i_w : bus.r0_s2_i_w;
        w_win_op_ok = (w_win_op == ALU_OP_ADD) || (w_win_op == ALU_OP_AND) ||
                      (w_win_op == ALU_OP_NOT);
        // alu_en_o_r is high in EXEC only for valid ops; invalid ops yield zero
        w_res       = bus.alu_en_o_r ? bus.alu_out_i_w : '0;
        if (w_res[DW-1])
            w_nzp = 3'b100;
        else if (w_res == '0)
            w_nzp = 3'b010;
        else
            w_nzp = 3'b001;
        w_accept    = r_owner ? (bus.r1_vld_o_r & bus.r1_rdy_i_w)
                              : (bus.r0_vld_o_r & bus.r0_rdy_i_w);
    end

    assign bus.busy_o_w = (r_state != ST_IDLE);

    // Scheduler FSM with all outputs registered
    always_ff @(posedge clk_i_w or negedge rst_i_w) begin
        if (!rst_i_w) begin
            r_state        <= ST_IDLE;
            r_owner        <= 1'b0;
            r_last         <= 1'b1;
            bus.r0_ack_o_r <= 1'b0;
            bus.r1_ack_o_r <= 1'b0;
            bus.r0_vld_o_r <= 1'b0;
            bus.r1_vld_o_r <= 1'b0;
            bus.res_o_r    <= '0;
            bus.nzp_o_r    <= 3'b000;
            bus.alu_en_o_r <= 1'b0;
            bus.alu_op_o_r <= 3'b000;
            bus.alu_s1_o_r <= '0;
            bus.alu_s2_o_r <= '0;
        end else begin
            // Ack is a single-cycle pulse following the grant edge
            bus.r0_ack_o_r <= 1'b0;
            bus.r1_ack_o_r <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        bus.alu_op_o_r <= w_win_op;
                        bus.alu_s1_o_r <= w_win_s1;
                        bus.alu_s2_o_r <= w_win_s2;
                        bus.alu_en_o_r <= w_win_op_ok;
                        r_owner        <= w_win;
                        r_last         <= w_win;
                        if (w_win)
                            bus.r1_ack_o_r <= 1'b1;
                        else
                            bus.r0_ack_o_r <= 1'b1;
                        r_state        <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    bus.alu_en_o_r <= 1'b0;
                    bus.res_o_r    <= w_res;
                    bus.nzp_o_r    <= w_nzp;
                    if (r_owner)
                        bus.r1_vld_o_r <= 1'b1;
                    else
                        bus.r0_vld_o_r <= 1'b1;
                    r_state        <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_accept) begin
                        bus.r0_vld_o_r <= 1'b0;
                        bus.r1_vld_o_r <= 1'b0;
                        r_state        <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
